// File: rtl/computer_pkg.sv
// rtl/computer_pkg.sv - shared opcodes, sequencer states and control-word bit indices
package computer_pkg;

    localparam int SIG_W = 17;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Encoding equals the step index so it can be presented directly as micro.
    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    localparam int SIG_HLT = 16;
    localparam int SIG_WE  = 15;
    localparam int SIG_OE  = 14;
    localparam int SIG_MI  = 13;
    localparam int SIG_AI  = 12;
    localparam int SIG_BI  = 11;
    localparam int SIG_AO  = 10;
    localparam int SIG_BO  = 9;
    localparam int SIG_EO  = 8;
    localparam int SIG_SUB = 7;
    localparam int SIG_OI  = 6;
    localparam int SIG_CE  = 5;
    localparam int SIG_J   = 4;
    localparam int SIG_CO  = 3;
    localparam int SIG_II  = 2;
    localparam int SIG_IO  = 1;
    localparam int SIG_FI  = 0;

endpackage

// File: rtl/microcode_decode.sv
// rtl/microcode_decode.sv - combinational map from step/opcode/flags to raw control word
// Ports: state, opcode, fz, fc in; word (ungated control word, never HLT),
// last_step (instruction retires on this step), halt_step (next state is HALT).
module microcode_decode
    import computer_pkg::*;
(
    input  state_e           state,
    input  logic [3:0]       opcode,
    input  logic             fz,
    input  logic             fc,
    output logic [SIG_W-1:0] word,
    output logic             last_step,
    output logic             halt_step
);

    always_comb begin
        word      = '0;
        last_step = 1'b0;
        halt_step = 1'b0;
        case (state)
            ST_T0: begin
                word[SIG_CO] = 1'b1;
                word[SIG_MI] = 1'b1;
            end
            ST_T1: begin
                word[SIG_OE] = 1'b1;
                word[SIG_II] = 1'b1;
                word[SIG_CE] = 1'b1;
            end
            ST_T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        word[SIG_IO] = 1'b1;
                        word[SIG_MI] = 1'b1;
                    end
                    OP_LDI: begin
                        word[SIG_IO] = 1'b1;
                        word[SIG_AI] = 1'b1;
                        last_step    = 1'b1;
                    end
                    OP_JMP: begin
                        word[SIG_IO] = 1'b1;
                        word[SIG_J]  = 1'b1;
                        last_step    = 1'b1;
                    end
                    // Untaken conditional jumps still spend the T2 step.
                    OP_JC: begin
                        word[SIG_IO] = fc;
                        word[SIG_J]  = fc;
                        last_step    = 1'b1;
                    end
                    OP_JZ: begin
                        word[SIG_IO] = fz;
                        word[SIG_J]  = fz;
                        last_step    = 1'b1;
                    end
                    OP_OUT: begin
                        word[SIG_AO] = 1'b1;
                        word[SIG_OI] = 1'b1;
                        last_step    = 1'b1;
                    end
                    OP_HLT: begin
                        last_step = 1'b1;
                        halt_step = 1'b1;
                    end
                    default: last_step = 1'b1;  // NOP and reserved opcodes
                endcase
            end
            ST_T3: begin
                case (opcode)
                    OP_LDA: begin
                        word[SIG_OE] = 1'b1;
                        word[SIG_AI] = 1'b1;
                        last_step    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        word[SIG_OE] = 1'b1;
                        word[SIG_BI] = 1'b1;
                    end
                    OP_STA: begin
                        word[SIG_AO] = 1'b1;
                        word[SIG_WE] = 1'b1;
                        last_step    = 1'b1;
                    end
                    default: last_step = 1'b1;  // unreachable; fall back to fetch
                endcase
            end
            ST_T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    word[SIG_EO]  = 1'b1;
                    word[SIG_AI]  = 1'b1;
                    word[SIG_FI]  = 1'b1;
                    word[SIG_SUB] = (opcode == OP_SUB);
                end
                last_step = 1'b1;
            end
            default: ;  // HALT: no raw signals, HLT is added by the sequencer
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - variable-length fetch/execute sequencer with retire counter
// Ports: clk, rst (sync active-high), step_en, opcode, FZ, FC in;
// signals (17-bit control word), micro (step index), halted, instr_count out.
module control_sequencer
    import computer_pkg::*;
#(
    parameter int INSTR_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step_en,
    input  logic [3:0]             opcode,
    input  logic                   FZ,
    input  logic                   FC,
    output logic [SIG_W-1:0]       signals,
    output logic [2:0]             micro,
    output logic                   halted,
    output logic [INSTR_CNT_W-1:0] instr_count
);

    state_e                 state_q, state_d;
    logic [INSTR_CNT_W-1:0] cnt_q, cnt_d;
    logic [SIG_W-1:0]       raw_word;
    logic                   last_step;
    logic                   halt_step;

    microcode_decode u_decode (
        .state     (state_q),
        .opcode    (opcode),
        .fz        (FZ),
        .fc        (FC),
        .word      (raw_word),
        .last_step (last_step),
        .halt_step (halt_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (step_en && state_q != ST_HALT) begin
            if (halt_step) begin
                state_d = ST_HALT;
            end else if (last_step) begin
                state_d = ST_T0;
            end else begin
                case (state_q)
                    ST_T0:   state_d = ST_T1;
                    ST_T1:   state_d = ST_T2;
                    ST_T2:   state_d = ST_T3;
                    ST_T3:   state_d = ST_T4;
                    default: state_d = ST_T0;
                endcase
            end
            if (last_step) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_T0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // HLT is held independent of step_en; every other bit is gated so a stall
    // never repeats CE or register loads.
    always_comb begin
        signals = raw_word & {SIG_W{step_en}};
        if (state_q == ST_HALT) begin
            signals          = '0;
            signals[SIG_HLT] = 1'b1;
        end
    end

    assign micro       = state_q;
    assign halted      = (state_q == ST_HALT);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard testbench for control_sequencer
module tb_control_sequencer;

    localparam logic [16:0] M_HLT = 17'h10000;
    localparam logic [16:0] M_WE  = 17'h08000;
    localparam logic [16:0] M_OE  = 17'h04000;
    localparam logic [16:0] M_MI  = 17'h02000;
    localparam logic [16:0] M_AI  = 17'h01000;
    localparam logic [16:0] M_BI  = 17'h00800;
    localparam logic [16:0] M_AO  = 17'h00400;
    localparam logic [16:0] M_EO  = 17'h00100;
    localparam logic [16:0] M_SUB = 17'h00080;
    localparam logic [16:0] M_OI  = 17'h00040;
    localparam logic [16:0] M_CE  = 17'h00020;
    localparam logic [16:0] M_J   = 17'h00010;
    localparam logic [16:0] M_CO  = 17'h00008;
    localparam logic [16:0] M_II  = 17'h00004;
    localparam logic [16:0] M_IO  = 17'h00002;
    localparam logic [16:0] M_FI  = 17'h00001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_en = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        fz = 1'b0;
    logic        fc = 1'b0;
    logic [16:0] signals;
    logic [2:0]  micro;
    logic        halted;
    logic [7:0]  instr_count;

    control_sequencer #(.INSTR_CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .step_en     (step_en),
        .opcode      (opcode),
        .FZ          (fz),
        .FC          (fc),
        .signals     (signals),
        .micro       (micro),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] sig;
        logic [2:0]  mi;
        logic        h;
        logic [7:0]  cnt;
        string       nm;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_cnt = 8'h00;

    // Monitor: the DUT presents a control word every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_vec++;
            if (signals !== e.sig || micro !== e.mi || halted !== e.h || instr_count !== e.cnt) begin
                n_bad++;
                $display("FAIL %s: got sig=%05h micro=%0d halted=%0b cnt=%02h, want sig=%05h micro=%0d halted=%0b cnt=%02h",
                         e.nm, signals, micro, halted, instr_count, e.sig, e.mi, e.h, e.cnt);
            end
        end
    end

    // One cycle: drive step_en, push the expectation for this cycle, advance.
    task automatic cyc(input logic en, input logic [16:0] sig, input logic [2:0] mi,
                       input logic h, input logic ret, input string nm);
        exp_t e;
        step_en = en;
        e.sig = sig; e.mi = mi; e.h = h; e.cnt = exp_cnt; e.nm = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) exp_cnt = 8'h00;
        else if (en && ret) exp_cnt = exp_cnt + 8'h01;
    endtask

    task automatic fetch(input logic [3:0] op);
        opcode = op;
        cyc(1'b1, M_CO | M_MI, 3'd0, 1'b0, 1'b0, "t0_fetch");
        cyc(1'b1, M_OE | M_II | M_CE, 3'd1, 1'b0, 1'b0, "t1_fetch");
    endtask

    initial begin
        rst = 1'b1;
        step_en = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, 17'h0, 3'd0, 1'b0, 1'b0, "reset_state");
        rst = 1'b0;

        // LDI
        fetch(4'h5);
        cyc(1'b1, M_IO | M_AI, 3'd2, 1'b0, 1'b1, "ldi_t2");
        // ADD then SUB
        fetch(4'h2);
        cyc(1'b1, M_IO | M_MI, 3'd2, 1'b0, 1'b0, "add_t2");
        cyc(1'b1, M_OE | M_BI, 3'd3, 1'b0, 1'b0, "add_t3");
        cyc(1'b1, M_EO | M_AI | M_FI, 3'd4, 1'b0, 1'b1, "add_t4");
        fetch(4'h3);
        cyc(1'b1, M_IO | M_MI, 3'd2, 1'b0, 1'b0, "sub_t2");
        cyc(1'b1, M_OE | M_BI, 3'd3, 1'b0, 1'b0, "sub_t3");
        cyc(1'b1, M_EO | M_AI | M_FI | M_SUB, 3'd4, 1'b0, 1'b1, "sub_t4");
        // Conditional jumps, each flag in both states
        fc = 1'b0; fz = 1'b1;
        fetch(4'h7);
        cyc(1'b1, 17'h0, 3'd2, 1'b0, 1'b1, "jc_not_taken");
        fc = 1'b1;
        fetch(4'h7);
        cyc(1'b1, M_IO | M_J, 3'd2, 1'b0, 1'b1, "jc_taken");
        fz = 1'b0;
        fetch(4'h8);
        cyc(1'b1, 17'h0, 3'd2, 1'b0, 1'b1, "jz_not_taken");
        fz = 1'b1;
        fetch(4'h8);
        cyc(1'b1, M_IO | M_J, 3'd2, 1'b0, 1'b1, "jz_taken");
        fetch(4'h6);
        cyc(1'b1, M_IO | M_J, 3'd2, 1'b0, 1'b1, "jmp_t2");
        fetch(4'hE);
        cyc(1'b1, M_AO | M_OI, 3'd2, 1'b0, 1'b1, "out_t2");
        fetch(4'hB);
        cyc(1'b1, 17'h0, 3'd2, 1'b0, 1'b1, "reserved_t2");
        // LDA with a 4-cycle stall in T3
        fetch(4'h1);
        cyc(1'b1, M_IO | M_MI, 3'd2, 1'b0, 1'b0, "lda_t2");
        for (int i = 0; i < 4; i++) cyc(1'b0, 17'h0, 3'd3, 1'b0, 1'b1, "lda_stall");
        cyc(1'b1, M_OE | M_AI, 3'd3, 1'b0, 1'b1, "lda_t3_resume");
        // STA aborted by reset before its write step
        fetch(4'h4);
        rst = 1'b1;
        cyc(1'b1, M_IO | M_MI, 3'd2, 1'b0, 1'b0, "sta_t2_rst");
        rst = 1'b0;
        cyc(1'b0, 17'h0, 3'd0, 1'b0, 1'b0, "sta_aborted");
        // 256 NOPs: counter wraps 0xFF -> 0x00
        for (int n = 0; n < 256; n++) begin
            fetch(4'h0);
            cyc(1'b1, 17'h0, 3'd2, 1'b0, 1'b1, "nop_t2");
        end
        cyc(1'b0, 17'h0, 3'd0, 1'b0, 1'b0, "nop_wrap");
        // Complete STA
        fetch(4'h4);
        cyc(1'b1, M_IO | M_MI, 3'd2, 1'b0, 1'b0, "sta_t2");
        cyc(1'b1, M_AO | M_WE, 3'd3, 1'b0, 1'b1, "sta_t3");
        // HLT, then HALT regardless of step_en
        fetch(4'hF);
        cyc(1'b1, 17'h0, 3'd2, 1'b0, 1'b1, "hlt_t2");
        for (int i = 0; i < 22; i++) cyc((i % 3) != 0, M_HLT, 3'd5, 1'b1, 1'b0, "halt_hold");
        rst = 1'b1;
        cyc(1'b1, M_HLT, 3'd5, 1'b1, 1'b0, "halt_rst");
        cyc(1'b1, M_CO | M_MI, 3'd0, 1'b0, 1'b0, "rst_held_t0");
        rst = 1'b0;
        fetch(4'h5);
        cyc(1'b1, M_IO | M_AI, 3'd2, 1'b0, 1'b1, "ldi_after_halt");
        cyc(1'b0, 17'h0, 3'd0, 1'b0, 1'b0, "final_count");

        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
